lcd_ctrl_sequencer: RTL
=======================

LCD_CTRL_SEQUENCER -- requirements
Module: lcd_ctrl_sequencer

Interface
REQ-001 Parameter WAIT_CYCLES, default 50000, sets the power-up wait in clk cycles before the first init byte.
REQ-002 Parameter FB_BYTES, default 504, sets the number of data bytes per frame (84x48 / 8).
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  reset, asynchronous and active-high.
REQ-005 Port refresh  input  1  frame request; sampled every cycle.
REQ-006 Port spi_busy  input  1  busy flag from the SPI master.
REQ-007 Port fb_rdata  input  8  frame-buffer read data, valid 1 cycle after fb_addr.
REQ-008 Port spi_start  output  1  one-cycle transfer strobe to the SPI master.
REQ-009 Port spi_data  output  8  byte to transmit.
REQ-010 Port spi_cmd  output  1  D/C level for the byte: 0 = command, 1 = display data.
REQ-011 Port fb_addr  output  9  frame-buffer read address, 0..FB_BYTES-1.
REQ-012 Port init_done  output  1  level; high once the init sequence has completed.
REQ-013 Port frame_busy  output  1  level; high while a frame transfer is in progress.
REQ-014 Port frame_done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-015 FSM states SHALL be: PWR_WAIT, INIT, READY, HDR, FETCH, LATCH, ISSUE, WAIT_ACK and WAIT_DONE.
REQ-016 PWR_WAIT SHALL count WAIT_CYCLES cycles (16-bit counter) and then enter INIT.
REQ-017 INIT SHALL send 6 fixed command bytes in order with spi_cmd=0: 0x21, 0xC0, 0x04, 0x14, 0x20, 0x0C.
REQ-018 Each byte transfer SHALL follow this sequence:
- ISSUE: spi_data/spi_cmd valid, spi_start=1 for exactly 1 cycle.
- WAIT_ACK: wait until spi_busy=1.
- WAIT_DONE: wait until spi_busy=0.
- Then advance to the next byte.
REQ-019 spi_data and spi_cmd SHALL remain stable from the ISSUE cycle until WAIT_DONE exits.
REQ-020 spi_start SHALL never be asserted while spi_busy=1 or in any state other than ISSUE.
REQ-021 After the 6th init byte completes, init_done SHALL go to 1 in the same cycle the FSM enters READY, and stay 1 until reset.
REQ-022 In READY, refresh=1 or a pending request SHALL start a frame:
- Set frame_busy=1.
- Enter HDR.
- Clear the pending flag.
REQ-023 HDR SHALL send the commands 0x40 (Y=0) then 0x80 (X=0) with spi_cmd=0.
REQ-024 The data phase SHALL run for byte index i = 0..FB_BYTES-1:
- FETCH: drive fb_addr=i.
- LATCH: capture fb_rdata into spi_data, set spi_cmd=1.
- ISSUE/WAIT_ACK/WAIT_DONE as in REQ-018.
REQ-025 After byte FB_BYTES-1 completes, the block SHALL pulse frame_done for 1 cycle, clear frame_busy in that same cycle, and return to READY.
REQ-026 The byte index SHALL reset to 0 at the start of each frame and SHALL never exceed FB_BYTES-1; no wrap-around within a frame.
REQ-027 Any refresh=1 seen while frame_busy=1 or before init_done SHALL set a 1-deep pending flag; further requests SHALL merge into it.
REQ-028 If pending is set at frame end, the next frame SHALL start on the cycle after frame_done, with no READY idle cycle.
REQ-029 If refresh=1 in the same cycle as frame_done, it SHALL be treated as pending, so the next frame starts immediately.
REQ-030 No timeout is required; if spi_busy never rises, the FSM SHALL hold in WAIT_ACK.

Reset
REQ-031 While reset=1, the block SHALL force:
- State=PWR_WAIT, all counters and the pending flag = 0.
- spi_start=0, spi_data=0x00, spi_cmd=0, fb_addr=0.
- init_done=0, frame_busy=0, frame_done=0.
REQ-032 Reset asserted mid-transfer SHALL abort immediately, and the full PWR_WAIT and INIT sequence SHALL repeat after release.

Verification (WAIT_CYCLES=4, FB_BYTES=8, behavioural SPI slave: busy rises 1 cycle after start, stays high 16 cycles)
REQ-033 Release reset, no refresh -> after 4 wait cycles, bytes 21,C0,04,14,20,0C are sent with spi_cmd=0; then init_done=1 and there is no further spi_start.
REQ-034 Fill fb with 0x00..0x07, pulse refresh after init -> bytes 40,80 (cmd=0), then 00..07 (cmd=1); frame_done pulses once and frame_busy falls in the same cycle.
REQ-035 Pulse refresh twice during frame 1 -> exactly one extra frame starts the cycle after frame_done; no third frame.
REQ-036 Refresh held high before init_done -> the first frame begins directly after init completes.
REQ-037 Assert reset while spi_busy=1 in byte 3 -> all outputs go to reset values at once; after release, PWR_WAIT and INIT restart from 0x21.
REQ-038 In every scenario, assert that spi_start is a 1-cycle pulse never coincident with spi_busy=1, and that fb_addr stays below FB_BYTES.

Source files
------------

// File: rtl/lcd_ctrl_sequencer.sv
// Sequencer for a PCD8544-style LCD: power-up wait, fixed init commands, then
// frame transfers (Y/X address header plus frame-buffer bytes) over an SPI master.
module lcd_ctrl_sequencer #(
    parameter int WAIT_CYCLES = 50000,
    parameter int FB_BYTES    = 504
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh,
    input  logic       spi_busy,
    input  logic [7:0] fb_rdata,
    output logic       spi_start,
    output logic [7:0] spi_data,
    output logic       spi_cmd,
    output logic [8:0] fb_addr,
    output logic       init_done,
    output logic       frame_busy,
    output logic       frame_done
);

    typedef enum logic [3:0] {
        PWR_WAIT, INIT, READY, HDR, FETCH, LATCH, ISSUE, WAIT_ACK, WAIT_DONE
    } state_e;

    typedef enum logic [1:0] {PH_INIT, PH_HDR, PH_DATA} phase_e;

    localparam logic [15:0] WAIT_LAST = 16'(WAIT_CYCLES - 1);
    localparam logic [8:0]  FB_LAST   = 9'(FB_BYTES - 1);

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [2:0]  cmd_idx_q, cmd_idx_d;
    logic [8:0]  fb_addr_q, fb_addr_d;
    logic [7:0]  spi_data_q, spi_data_d;
    logic        spi_cmd_q, spi_cmd_d;
    logic        init_done_q, init_done_d;
    logic        frame_busy_q, frame_busy_d;
    logic        frame_done_q, frame_done_d;
    logic        pending_q, pending_d;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h21;
            3'd1:    return 8'hC0;
            3'd2:    return 8'h04;
            3'd3:    return 8'h14;
            3'd4:    return 8'h20;
            default: return 8'h0C;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= PWR_WAIT;
            phase_q      <= PH_INIT;
            wait_cnt_q   <= 16'd0;
            cmd_idx_q    <= 3'd0;
            fb_addr_q    <= 9'd0;
            spi_data_q   <= 8'h00;
            spi_cmd_q    <= 1'b0;
            init_done_q  <= 1'b0;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            wait_cnt_q   <= wait_cnt_d;
            cmd_idx_q    <= cmd_idx_d;
            fb_addr_q    <= fb_addr_d;
            spi_data_q   <= spi_data_d;
            spi_cmd_q    <= spi_cmd_d;
            init_done_q  <= init_done_d;
            frame_busy_q <= frame_busy_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        wait_cnt_d   = wait_cnt_q;
        cmd_idx_d    = cmd_idx_q;
        fb_addr_d    = fb_addr_q;
        spi_data_d   = spi_data_q;
        spi_cmd_d    = spi_cmd_q;
        init_done_d  = init_done_q;
        frame_busy_d = frame_busy_q;
        frame_done_d = 1'b0;
        pending_d    = pending_q;

        // Requests that cannot be served right now collapse into one pending frame.
        if (refresh && (frame_busy_q || !init_done_q)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            PWR_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = INIT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            INIT: begin
                spi_data_d = init_byte(cmd_idx_q);
                spi_cmd_d  = 1'b0;
                phase_d    = PH_INIT;
                state_d    = ISSUE;
            end
            READY: begin
                if (refresh || pending_q) begin
                    frame_busy_d = 1'b1;
                    pending_d    = 1'b0;
                    cmd_idx_d    = 3'd0;
                    fb_addr_d    = 9'd0;
                    state_d      = HDR;
                end
            end
            HDR: begin
                spi_data_d = cmd_idx_q[0] ? 8'h80 : 8'h40;
                spi_cmd_d  = 1'b0;
                phase_d    = PH_HDR;
                state_d    = ISSUE;
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                spi_data_d = fb_rdata;
                spi_cmd_d  = 1'b1;
                phase_d    = PH_DATA;
                state_d    = ISSUE;
            end
            ISSUE: begin
                if (!spi_busy) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (spi_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // The byte has completed once the master drops busy; pick the next byte.
                if (!spi_busy) begin
                    case (phase_q)
                        PH_INIT: begin
                            if (cmd_idx_q == 3'd5) begin
                                cmd_idx_d   = 3'd0;
                                init_done_d = 1'b1;
                                state_d     = READY;
                            end else begin
                                cmd_idx_d = cmd_idx_q + 3'd1;
                                state_d   = INIT;
                            end
                        end
                        PH_HDR: begin
                            if (cmd_idx_q == 3'd1) begin
                                cmd_idx_d = 3'd0;
                                fb_addr_d = 9'd0;
                                state_d   = FETCH;
                            end else begin
                                cmd_idx_d = cmd_idx_q + 3'd1;
                                state_d   = HDR;
                            end
                        end
                        PH_DATA: begin
                            if (fb_addr_q == FB_LAST) begin
                                frame_done_d = 1'b1;
                                frame_busy_d = 1'b0;
                                state_d      = READY;
                            end else begin
                                fb_addr_d = fb_addr_q + 9'd1;
                                state_d   = FETCH;
                            end
                        end
                        default: state_d = READY;
                    endcase
                end
            end
            default: state_d = PWR_WAIT;
        endcase
    end

    assign spi_start  = (state_q == ISSUE) && !spi_busy;
    assign spi_data   = spi_data_q;
    assign spi_cmd    = spi_cmd_q;
    assign fb_addr    = fb_addr_q;
    assign init_done  = init_done_q;
    assign frame_busy = frame_busy_q;
    assign frame_done = frame_done_q;

endmodule
